trng_health_monitor: RTL

- Consumer and reader for the raw TRNG byte stream. Sits between the TRNG core's random_byte output and downstream logic.
- Runs the two SP 800-90B continuous health tests on every sampled byte: repetition count test (RCT) and adaptive proportion test (APT).
- Delivers only post-startup, health-passed bytes through a small FIFO with a valid/ready handshake.
- Latches sticky alarm flags and halts output on any failure until software clears it.

---
 rtl/trng_pkg.sv | 23 ++
 rtl/trng_byte_fifo.sv | 72 +++++++
 rtl/trng_health_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG health monitor.
package trng_pkg;

  // Monitor operating states.
  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_ALARM   = 2'd2
  } state_e;

  localparam int DATA_W_DEF          = 8;
  localparam int RCT_CUTOFF_DEF      = 4;
  localparam int APT_WINDOW_DEF      = 64;
  localparam int APT_CUTOFF_DEF      = 13;
  localparam int STARTUP_SAMPLES_DEF = 64;
  localparam int FIFO_DEPTH_DEF      = 4;

  // Counter width able to hold the value n itself (counters saturate at n).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/trng_byte_fifo.sv
// Small output FIFO: synchronous push/pop, flush, power-of-2 depth.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Head is read combinationally so a byte is visible the cycle after it lands.
  assign head_data = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy update; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/trng_health_monitor.sv
// Continuous health monitor (repetition count + adaptive proportion tests)
// gating the raw TRNG byte stream into a small output FIFO.
module trng_health_monitor
  import trng_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int RCT_CUTOFF      = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW      = APT_WINDOW_DEF,
  parameter int APT_CUTOFF      = APT_CUTOFF_DEF,
  parameter int STARTUP_SAMPLES = STARTUP_SAMPLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              clear_alarm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              health_ok,
  output logic              rct_fail,
  output logic              apt_fail
);

  localparam int RCT_W = cnt_w(RCT_CUTOFF);
  localparam int APT_W = cnt_w(APT_CUTOFF);
  localparam int IDX_W = cnt_w(APT_WINDOW);
  localparam int SU_W  = cnt_w(STARTUP_SAMPLES);
  localparam logic [RCT_W-1:0] RCT_MAX = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_W-1:0] APT_MAX = APT_W'(APT_CUTOFF);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(APT_WINDOW);
  localparam logic [SU_W-1:0]  SU_MAX  = SU_W'(STARTUP_SAMPLES);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [RCT_W-1:0]  rct_cnt_q, rct_cnt_d;
  logic [DATA_W-1:0] apt_ref_q, apt_ref_d;
  logic [APT_W-1:0]  apt_cnt_q, apt_cnt_d;
  logic [IDX_W-1:0]  apt_idx_q, apt_idx_d;
  logic [SU_W-1:0]   su_cnt_q, su_cnt_d;
  logic              rct_fail_q, rct_fail_d;
  logic              apt_fail_q, apt_fail_d;
  logic              health_ok_q, health_ok_d;

  logic              accept;
  logic [RCT_W-1:0]  rct_cnt_upd;
  logic [DATA_W-1:0] apt_ref_upd;
  logic [APT_W-1:0]  apt_cnt_upd;
  logic [IDX_W-1:0]  apt_idx_upd;
  logic [SU_W-1:0]   su_cnt_upd;
  logic              rct_hit, apt_hit;
  logic              fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign accept = sample_valid && (state_q != ST_ALARM);

  // Health-test counters as they would be after the incoming sample; a zero
  // count/index marks "no sample seen yet since reset or clear".
  always_comb begin
    rct_cnt_upd = RCT_W'(1);
    if (rct_cnt_q != '0 && sample_data == last_q)
      rct_cnt_upd = (rct_cnt_q == RCT_MAX) ? RCT_MAX : rct_cnt_q + RCT_W'(1);

    apt_ref_upd = apt_ref_q;
    apt_cnt_upd = apt_cnt_q;
    apt_idx_upd = apt_idx_q + IDX_W'(1);
    if (apt_idx_q == '0 || apt_idx_q == IDX_MAX) begin
      apt_ref_upd = sample_data;
      apt_cnt_upd = APT_W'(1);
      apt_idx_upd = IDX_W'(1);
    end else if (sample_data == apt_ref_q && apt_cnt_q != APT_MAX) begin
      apt_cnt_upd = apt_cnt_q + APT_W'(1);
    end

    su_cnt_upd = (su_cnt_q == SU_MAX) ? SU_MAX : su_cnt_q + SU_W'(1);
    rct_hit    = accept && (rct_cnt_upd == RCT_MAX);
    apt_hit    = accept && (apt_cnt_upd == APT_MAX);
  end

  // Next-state logic: test, promote, enqueue, alarm and clear.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rct_cnt_d  = rct_cnt_q;
    apt_ref_d  = apt_ref_q;
    apt_cnt_d  = apt_cnt_q;
    apt_idx_d  = apt_idx_q;
    su_cnt_d   = su_cnt_q;
    rct_fail_d = rct_fail_q;
    apt_fail_d = apt_fail_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;

    case (state_q)
      ST_STARTUP, ST_RUN: begin
        if (accept) begin
          last_d    = sample_data;
          rct_cnt_d = rct_cnt_upd;
          apt_ref_d = apt_ref_upd;
          apt_cnt_d = apt_cnt_upd;
          apt_idx_d = apt_idx_upd;
          if (rct_hit || apt_hit) begin
            state_d    = ST_ALARM;
            rct_fail_d = rct_fail_q | rct_hit;
            apt_fail_d = apt_fail_q | apt_hit;
            fifo_flush = 1'b1;
          end else if (state_q == ST_STARTUP) begin
            su_cnt_d = su_cnt_upd;
            if (su_cnt_upd == SU_MAX) state_d = ST_RUN;
          end else begin
            fifo_push = 1'b1;
          end
        end
      end
      ST_ALARM: begin
        if (clear_alarm) begin
          state_d    = ST_STARTUP;
          rct_fail_d = 1'b0;
          apt_fail_d = 1'b0;
          rct_cnt_d  = '0;
          apt_cnt_d  = '0;
          apt_idx_d  = '0;
          su_cnt_d   = '0;
          fifo_flush = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    health_ok_d = (state_d == ST_RUN);
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STARTUP;
      last_q      <= '0;
      rct_cnt_q   <= '0;
      apt_ref_q   <= '0;
      apt_cnt_q   <= '0;
      apt_idx_q   <= '0;
      su_cnt_q    <= '0;
      rct_fail_q  <= 1'b0;
      apt_fail_q  <= 1'b0;
      health_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rct_cnt_q   <= rct_cnt_d;
      apt_ref_q   <= apt_ref_d;
      apt_cnt_q   <= apt_cnt_d;
      apt_idx_q   <= apt_idx_d;
      su_cnt_q    <= su_cnt_d;
      rct_fail_q  <= rct_fail_d;
      apt_fail_q  <= apt_fail_d;
      health_ok_q <= health_ok_d;
    end
  end

  // The FIFO only ever holds bytes while in RUN (it is flushed on entry to
  // ALARM and only pushed in RUN), so its occupancy alone drives out_valid.
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign health_ok = health_ok_q;
  assign rct_fail  = rct_fail_q;
  assign apt_fail  = apt_fail_q;

  trng_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (sample_data),
    .pop       (fifo_pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Full is handled inside the FIFO (drop unless popping); kept visible here
  // only for debug probing.
  logic dbg_fifo_full;
  assign dbg_fifo_full = fifo_full;

endmodule
